water_supply_arbiter: RTL and testbench

- Shares the single building water-inlet resource (hot/cold supply line) among N washer controllers so that only one washer fills at a time.
- Each washer raises a request before its fill step and releases the request when done. The arbiter grants access round-robin, enforces a maximum hold time, and inserts a guard gap between grants so the valves can close.
- Sits between the washer FSM instances and the physical inlet valve drivers.

---
 rtl/water_supply_arbiter_pkg.sv | 19 +
 rtl/water_supply_arbiter_rr_picker.sv | 28 ++
 rtl/water_supply_arbiter.sv | 141 ++++++++++++++
 tb/tb_water_supply_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/water_supply_arbiter_pkg.sv
// Shared types and defaults for the water-inlet arbiter family.
// Stats counters are built only when WATER_ARB_STATS_EN is defined.
package water_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01,
      ST_GAP   = 2'b10
   } arb_state_e;

   localparam logic [7:0]  DEF_MAX_HOLD   = 8'd32;
   localparam logic [7:0]  DEF_GAP_CYCLES = 8'd2;
   localparam int unsigned STATS_W        = 16;

   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/water_supply_arbiter_rr_picker.sv
// Combinational round-robin selector: first set req bit at or above ptr,
// wrapping around. Shared by other shared-resource arbiters.
module rr_picker #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] sel,
   output logic             any
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      sel = '0;
      any = 1'b0;
      idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = IDX_W'((32'(ptr) + i) % N_REQ);
         if (!any && req[idx]) begin
            any = 1'b1;
            sel = idx;
         end
      end
   end

endmodule

// File: rtl/water_supply_arbiter.sv
// Round-robin arbiter for the shared building water inlet with hold limit
// and valve-closing guard gap. Optional stats outputs: WATER_ARB_STATS_EN.
module water_supply_arbiter
   import water_arb_pkg::*;
#(
   parameter int unsigned          N_REQ      = 4,
   parameter int unsigned          CNT_W      = 8,
   parameter logic [CNT_W-1:0]     MAX_HOLD   = CNT_W'(DEF_MAX_HOLD),
   parameter logic [CNT_W-1:0]     GAP_CYCLES = CNT_W'(DEF_GAP_CYCLES),
   parameter int unsigned          IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   done,
   output logic [N_REQ-1:0]   grant,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_id,
   output logic               timeout,
   output logic               busy
`ifdef WATER_ARB_STATS_EN
   ,
   output logic [STATS_W-1:0] grant_count,
   output logic [STATS_W-1:0] timeout_count
`endif
);

   localparam logic [CNT_W-1:0] HOLD_LAST = MAX_HOLD - 1'b1;
   localparam logic [CNT_W-1:0] GAP_LAST  = GAP_CYCLES - 1'b1;
   localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);

   arb_state_e       state_q;
   logic [N_REQ-1:0] grant_q;
   logic [IDX_W-1:0] grant_id_q;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic [CNT_W-1:0] gap_cnt_q;
   logic             timeout_q;

   logic [IDX_W-1:0] pick_sel;
   logic             pick_any;
   logic             rel_normal;
   logic             rel_limit;
   logic [IDX_W-1:0] ptr_next;

   rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .req (req),
      .ptr (rr_ptr_q),
      .sel (pick_sel),
      .any (pick_any)
   );

   // Only the grantee's lines are looked at, so X on other lines is harmless.
   assign rel_normal = done[grant_id_q] | ~req[grant_id_q];
   assign rel_limit  = (MAX_HOLD != '0) && (hold_cnt_q == HOLD_LAST);
   assign ptr_next   = (grant_id_q == IDX_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  state_q    <= ST_GRANT;
                  grant_q    <= ONE << pick_sel;
                  grant_id_q <= pick_sel;
                  hold_cnt_q <= '0;
               end
            end
            ST_GRANT: begin
               if (hold_cnt_q != '1) begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
               if (rel_normal || rel_limit) begin
                  grant_q   <= '0;
                  rr_ptr_q  <= ptr_next;
                  timeout_q <= rel_limit && !rel_normal;
                  if (GAP_CYCLES == '0) begin
                     state_q <= ST_IDLE;
                  end else begin
                     state_q   <= ST_GAP;
                     gap_cnt_q <= '0;
                  end
               end
            end
            ST_GAP: begin
               gap_cnt_q <= gap_cnt_q + 1'b1;
               if (gap_cnt_q == GAP_LAST) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_id    = grant_id_q;
   assign timeout     = timeout_q;
   assign busy        = (state_q != ST_IDLE);

`ifdef WATER_ARB_STATS_EN
   logic [STATS_W-1:0] grant_cnt_q;
   logic [STATS_W-1:0] timeout_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_cnt_q   <= '0;
         timeout_cnt_q <= '0;
      end else begin
         if (state_q == ST_IDLE && pick_any) begin
            grant_cnt_q <= sat_inc(grant_cnt_q);
         end
         if (state_q == ST_GRANT && rel_limit && !rel_normal) begin
            timeout_cnt_q <= sat_inc(timeout_cnt_q);
         end
      end
   end

   assign grant_count   = grant_cnt_q;
   assign timeout_count = timeout_cnt_q;
`endif

   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant_q));

endmodule

// File: tb/tb_water_supply_arbiter.sv
// Directed bench for water_supply_arbiter: table of per-cycle vectors plus
// hand-written sequences for timeout, coincident release, drop and async reset.
module tb_water_supply_arbiter;
   import water_arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, done, grant;
   logic       grant_valid, timeout, busy;
   logic [1:0] grant_id;

   logic [3:0] req0, done0, grant0;
   logic       grant_valid0, timeout0, busy0;
   logic [1:0] grant_id0;

`ifdef WATER_ARB_STATS_EN
   logic [15:0] grant_count, timeout_count, grant_count0, timeout_count0;
`endif

   always #5 clk = ~clk;

   water_supply_arbiter #(
      .N_REQ      (4),
      .CNT_W      (8),
      .MAX_HOLD   (8'd8),
      .GAP_CYCLES (8'd2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .timeout     (timeout),
      .busy        (busy)
`ifdef WATER_ARB_STATS_EN
      ,
      .grant_count   (grant_count),
      .timeout_count (timeout_count)
`endif
   );

   // Unlimited hold, no gap.
   water_supply_arbiter #(
      .N_REQ      (4),
      .CNT_W      (8),
      .MAX_HOLD   (8'd0),
      .GAP_CYCLES (8'd0)
   ) dut0 (
      .clk         (clk),
      .rst         (rst),
      .req         (req0),
      .done        (done0),
      .grant       (grant0),
      .grant_valid (grant_valid0),
      .grant_id    (grant_id0),
      .timeout     (timeout0),
      .busy        (busy0)
`ifdef WATER_ARB_STATS_EN
      ,
      .grant_count   (grant_count0),
      .timeout_count (timeout_count0)
`endif
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] grant;
      logic [1:0] id;
      logic       to;
      logic       busy;
   } vec_t;

   vec_t vecs[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic void add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                               input logic [1:0] id, input logic to, input logic b);
      vec_t v;
      v.req = r; v.done = d; v.grant = g; v.id = id; v.to = to; v.busy = b;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b0; req = '0; done = '0; req0 = '0; done0 = '0;
      tick; tick;
      rst = 1'b1;
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         req  = vecs[i].req;
         done = vecs[i].done;
         tick;
         chk($sformatf("row%0d {grant,valid,id,to,busy}", i),
             32'({grant, grant_valid, grant_id, timeout, busy}),
             32'({vecs[i].grant, |vecs[i].grant, vecs[i].id, vecs[i].to, vecs[i].busy}));
      end
      done = '0;
   endtask

   int rr_lo;
   int bad;

   initial begin
      rst = 1'b0; req = '0; done = '0; req0 = '0; done0 = '0;

      // Single request: grant next cycle, done releases, two gap cycles.
      add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1);
      add(4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b1);
      add(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1);
      add(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
      rr_lo = vecs.size();
      // All four requesting: order 0,1,2,3,0, each releasing by done.
      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < 3; k++) add(4'b1111, 4'b0000, 4'(1 << g), 2'(g), 1'b0, 1'b1);
         add(4'b1111, 4'(1 << g), 4'b0000, 2'(g), 1'b0, 1'b1);
         add(4'b1111, 4'b0000, 4'b0000, 2'(g), 1'b0, 1'b1);
         add(4'b1111, 4'b0000, 4'b0000, 2'(g), 1'b0, 1'b0);
      end
      add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1);

      tick; tick;
      chk("reset state", 32'({grant, grant_valid, grant_id, timeout, busy}), 32'd0);
      rst = 1'b1;
      run_rows(0, rr_lo - 1);

      do_reset;
      run_rows(rr_lo, vecs.size() - 1);

      // Timeout: 8 grant cycles, pulse on release, re-grant after gap + idle.
      do_reset;
      req = 4'b0001;
      for (int k = 1; k <= 12; k++) begin
         tick;
         chk($sformatf("timeout grant e%0d", k), 32'(grant), (k <= 8 || k == 12) ? 32'd1 : 32'd0);
         chk($sformatf("timeout pulse e%0d", k), 32'(timeout), (k == 9) ? 32'd1 : 32'd0);
      end
`ifdef WATER_ARB_STATS_EN
      chk("stats grant_count", 32'(grant_count), 32'd2);
      chk("stats timeout_count", 32'(timeout_count), 32'd1);
`endif

      // done coinciding with the hold limit is a normal release.
      do_reset;
      req = 4'b0001;
      repeat (8) tick;
      chk("coincide pre grant", 32'(grant), 32'd1);
      done = 4'b0001;
      tick;
      done = '0;
      chk("coincide release grant", 32'(grant), 32'd0);
      chk("coincide release timeout", 32'(timeout), 32'd0);
      tick;
      chk("coincide after timeout", 32'(timeout), 32'd0);

      // Grantee drops req; pending requester 3 served after the gap.
      do_reset;
      req = 4'b1001;
      tick;
      chk("drop first grant", 32'(grant), 32'h1);
      tick;
      req = 4'b1000;
      tick;
      chk("drop release", 32'({grant, busy}), 32'({4'b0000, 1'b1}));
      tick;
      chk("drop gap", 32'(grant), 32'h0);
      tick;
      chk("drop idle", 32'({grant, busy}), 32'({4'b0000, 1'b0}));
      tick;
      chk("drop regrant", 32'({grant, grant_id}), 32'({4'b1000, 2'd3}));

      // X on non-granted lines is ignored; then async reset mid-grant.
      do_reset;
      req = 4'b0001;
      tick;
      req = 4'bxxx1;
      done = 4'bxxx0;
      tick;
      chk("x on other lines", 32'(grant), 32'h1);
      req = 4'b1000;
      done = '0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async reset clears", 32'({grant, grant_valid, timeout, busy}), 32'd0);
`ifdef WATER_ARB_STATS_EN
      chk("async reset counters", 32'({grant_count, timeout_count}), 32'd0);
`endif
      tick;
      rst = 1'b1;
      tick;
      chk("post reset wrap grant", 32'({grant, grant_id, timeout}), 32'({4'b1000, 2'd3, 1'b0}));

      // No limit, no gap: long hold, then re-grant straight after idle.
      do_reset;
      req0 = 4'b0011;
      tick;
      chk("nogap first grant", 32'(grant0), 32'h1);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         tick;
         if (grant0 !== 4'b0001 || timeout0 !== 1'b0) bad++;
      end
      chk("unlimited hold glitches", 32'(bad), 32'd0);
      done0 = 4'b0001;
      tick;
      done0 = '0;
      chk("nogap release", 32'({grant0, busy0, timeout0}), 32'd0);
      tick;
      chk("nogap regrant", 32'({grant0, grant_id0}), 32'({4'b0010, 2'd1}));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
